uart_frame_checker: RTL

- Synthesizable, parametrised successor to the bench-side UART print monitor: passively samples the serial TX_OUT line, deserialises each frame, and checks parity and stop bits.
- Compares each received word against an expected-data FIFO that the stimulus side loads.
- Exposes per-frame result pulses and saturating match/error counters, so benches and on-chip self-test get pass/fail without reading log text.

---
 rtl/uart_frame_checker.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_checker.sv
// UART frame checker: deserialises TX_OUT, checks parity and stop bits,
// compares each word against an expected-data FIFO and keeps statistics.
module uart_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  TX_OUT,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  exp_valid,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  clr_cnt,
  output logic                  frame_done,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic                  mismatch,
  output logic                  unexpected,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  exp_full,
  output logic                  exp_empty,
  output logic                  overflow
);
  localparam int PW = $clog2(PRESCALE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] BIT_T  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] HALF_T = PW'(PRESCALE / 2 - 1);
  localparam logic [3:0]    LAST_D = 4'(DATA_WIDTH - 1);
  localparam logic [1:0]    LAST_S = 2'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE
  } state_t;

  state_t state, state_nx;

  logic                  s1, s2, line_q;
  logic                  fall, tick_hit, half_hit;
  logic [PW-1:0]         tick;
  logic [3:0]            bit_idx;
  logic [1:0]            stop_idx;
  logic                  par_en_q, par_typ_q;
  logic                  par_err_q, frm_err_q;
  logic [DATA_WIDTH-1:0] shreg;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [AW:0]           count;
  logic                  push, pop, any_err;

  // Sync flops idle high so reset never looks like a start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      line_q <= 1'b1;
    end else begin
      s1     <= TX_OUT;
      s2     <= s1;
      line_q <= s2;
    end
  end

  assign fall     = line_q & ~s2;
  assign tick_hit = tick == BIT_T;
  assign half_hit = tick == HALF_T;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (fall) state_nx = START;
      START:  if (half_hit) state_nx = s2 ? IDLE : DATA;
      DATA:   if (tick_hit && bit_idx == LAST_D)
                state_nx = par_en_q ? PARITY : STOP;
      PARITY: if (tick_hit) state_nx = STOP;
      STOP:   if (tick_hit && stop_idx == LAST_S)
                state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick       <= '0;
      bit_idx    <= '0;
      stop_idx   <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      shreg      <= '0;
      frame_data <= '0;
    end else begin
      if (state == IDLE || state_nx != state || tick_hit)
        tick <= '0;
      else
        tick <= tick + 1'b1;
      case (state)
        IDLE: if (fall) begin
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
        end
        START: begin
          bit_idx   <= '0;
          stop_idx  <= '0;
          par_err_q <= 1'b0;
          frm_err_q <= 1'b0;
        end
        DATA: if (tick_hit) begin
          shreg   <= {s2, shreg[DATA_WIDTH-1:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        PARITY: if (tick_hit)
          par_err_q <= ((^shreg) ^ s2) != par_typ_q;
        STOP: if (tick_hit) begin
          frm_err_q <= frm_err_q | ~s2;
          stop_idx  <= stop_idx + 1'b1;
          if (stop_idx == LAST_S) frame_data <= shreg;
        end
        default: ;
      endcase
    end
  end

  assign frame_done  = state == DONE;
  assign exp_empty   = count == '0;
  assign exp_full    = count == DEPTH;
  assign pop         = frame_done & ~exp_empty;
  assign push        = exp_valid & (~exp_full | pop);
  assign parity_err  = frame_done & par_err_q;
  assign framing_err = frame_done & frm_err_q;
  assign unexpected  = frame_done & exp_empty;
  assign mismatch    = pop & (mem[rptr] != frame_data);
  assign any_err     = parity_err | framing_err
                     | mismatch | unexpected;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= exp_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
    end
  end

  // Clear has priority over a frame completing in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt <= '0;
      err_cnt   <= '0;
      overflow  <= 1'b0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
      err_cnt   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (exp_valid && exp_full && !pop) overflow <= 1'b1;
      if (frame_done) begin
        if (any_err) begin
          if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        end else if (!(&match_cnt)) begin
          match_cnt <= match_cnt + 1'b1;
        end
      end
    end
  end

endmodule
